alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: SETTLE, default 1, number of cycles alu_ee is held before the result is captured (legal range 1..15).
REQ-002 Port: clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: req_valid  in  1  an operation request is present.
REQ-005 Port: req_ready  out  1  the sequencer accepts the request this cycle.
REQ-006 Port: req_op  in  4  ALU mode code: ADD=0, ADC=1, SUB=2, INC=3, DEC=4, AND=5, OR=6, XOR=7, SQRT=8, identical to the ALU_* codes in symbols.vh.
REQ-007 Port: req_a, req_b  in  8 each  operands.
REQ-008 Port: alu_a, alu_b  out  8 each  registered operands to the ALU.
REQ-009 Port: alu_mode  out  4  registered mode to the ALU.
REQ-010 Port: alu_ee  out  1  ALU evaluate enable.
REQ-011 Port: alu_eo  out  1  ALU bus-output enable.
REQ-012 Port: alu_out  in  8  ALU result bus; valid only while alu_eo=1.
REQ-013 Port: alu_zero, alu_carry  in  1 each  ALU flags.
REQ-014 Port: res_valid  out  1 / res_ready  in  1  result handshake.
REQ-015 Port: res_data  out  8 / res_zero, res_carry, res_err  out  1 each  result fields.
REQ-016 Port: flag_z, flag_c  out  1 each  persistent flags register.
REQ-017 Port: op_count  out  8  count of completed legal operations.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, EVAL, CAPTURE, DONE.
REQ-019 IDLE: req_ready=1; a transfer (req_valid&req_ready) SHALL latch req_a/req_b/req_op into alu_a/alu_b/alu_mode and go to LOAD if req_op<=8, else to DONE with res_err=1 and res_data=0.
REQ-020 req_ready SHALL be 1 only in IDLE; req_valid in any other state SHALL be ignored.
REQ-021 LOAD: one cycle, alu_ee=0, alu_eo=0; then EVAL.
REQ-022 EVAL: alu_ee=1 for exactly SETTLE cycles, counted by a settle counter cleared on entry; then CAPTURE.
REQ-023 CAPTURE: one cycle, alu_ee=1 and alu_eo=1; on its closing edge alu_out->res_data, alu_zero->res_zero and flag_z, alu_carry->res_carry and flag_c, res_err=0, op_count+=1 (mod 256); then DONE.
REQ-024 alu_eo SHALL be 1 only in CAPTURE; alu_ee SHALL be 1 only in EVAL and CAPTURE.
REQ-025 alu_a, alu_b, alu_mode SHALL remain stable from LOAD through CAPTURE.
REQ-026 DONE: res_valid=1; res_data, res_zero, res_carry, res_err SHALL hold until the edge where res_ready=1, then go to IDLE.
REQ-027 Latency: res_valid SHALL rise on the (SETTLE+3)th rising edge after the accepting edge for legal ops, and on the 1st edge after it for illegal ops.
REQ-028 Illegal ops SHALL NOT pulse alu_ee or alu_eo and SHALL NOT change flag_z, flag_c, or op_count.
REQ-029 flag_z, flag_c SHALL change only in CAPTURE.
REQ-030 op_count SHALL wrap from 255 to 0.

Reset
REQ-031 rst=1 SHALL immediately, without waiting for a clock edge, force the state to IDLE and drive req_ready=1 plus all other outputs to 0 (including alu_ee, alu_eo, flag_z, flag_c, op_count, and res_*).
REQ-032 Reset asserted mid-operation SHALL discard the operation; no result SHALL be produced after release.
REQ-033 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-034 ADD a=200, b=100, SETTLE=1, ALU model returns 44, carry=1 -> res_valid on the 4th edge after accept; res_data=0x2C, res_carry=1, res_zero=0; flag_c=1; op_count=1.
REQ-035 SUB a=5, b=5, model returns 0, zero=1 -> res_data=0, res_zero=1, res_carry=0, flag_z=1; alu_eo high for exactly 1 cycle.
REQ-036 req_op=4'hF -> res_valid on the 1st edge after accept, res_err=1, res_data=0; alu_ee and alu_eo never high; flags and op_count unchanged.
REQ-037 Hold res_ready=0 for 10 cycles with req_valid=1 and req_a changing -> res_valid and res_data stable, req_ready=0, no new accept; on res_ready=1, IDLE on the next edge.
REQ-038 Assert rst during EVAL with SETTLE=4 -> alu_ee falls asynchronously; after release, state IDLE, flags 0, op_count 0, no res_valid.
REQ-039 Issue 256 back-to-back legal ops -> op_count reads 0, and 1 after the 257th op.

Source files
------------

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Sequences a single operation through an external 8-bit ALU.
//                A request is latched into the ALU operand/mode registers,
//                the ALU is given SETTLE evaluate cycles, then its bus output
//                is enabled for one cycle and the result and flags are
//                captured. The result is held until the consumer accepts it.
//                Illegal mode codes bypass the ALU and return an error result.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SETTLE                   evaluate cycles before capture (1..15)
//  Ports
//    clk, rst                 clock, asynchronous active-high reset
//    req_valid/req_ready      request handshake
//    req_op, req_a, req_b     requested ALU mode and operands
//    alu_a, alu_b, alu_mode   registered operands/mode driven to the ALU
//    alu_ee, alu_eo           ALU evaluate enable / bus output enable
//    alu_out, alu_zero,
//    alu_carry                ALU result bus and flags (valid while alu_eo)
//    res_valid/res_ready      result handshake
//    res_data, res_zero,
//    res_carry, res_err       result fields
//    flag_z, flag_c           persistent flags from the last legal operation
//    op_count                 completed legal operations, wraps at 256
// ============================================================================
module alu_sequencer #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_mode,
  output logic       alu_ee,
  output logic       alu_eo,
  input  logic [7:0] alu_out,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_zero,
  output logic       res_carry,
  output logic       res_err,
  output logic       flag_z,
  output logic       flag_c,
  output logic [7:0] op_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_EVAL    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // Highest legal mode code (SQRT).
  localparam logic [3:0] OP_MAX      = 4'd8;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [3:0] mode_q, mode_d;
  logic [7:0] res_data_q, res_data_d;
  logic       res_zero_q, res_zero_d;
  logic       res_carry_q, res_carry_d;
  logic       res_err_q, res_err_d;
  logic       flag_z_q, flag_z_d;
  logic       flag_c_q, flag_c_d;
  logic [7:0] op_count_q, op_count_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_carry_d = res_carry_q;
    res_err_d   = res_err_q;
    flag_z_d    = flag_z_q;
    flag_c_d    = flag_c_q;
    op_count_d  = op_count_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_d    = req_a;
          b_d    = req_b;
          mode_d = req_op;
          if (req_op <= OP_MAX) begin
            state_d = S_LOAD;
          end else begin
            // Illegal code: answer immediately without touching the ALU.
            state_d     = S_DONE;
            res_err_d   = 1'b1;
            res_data_d  = 8'd0;
            res_zero_d  = 1'b0;
            res_carry_d = 1'b0;
          end
        end
      end
      S_LOAD: begin
        cnt_d   = 4'd0;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_CAPTURE: begin
        res_data_d  = alu_out;
        res_zero_d  = alu_zero;
        res_carry_d = alu_carry;
        res_err_d   = 1'b0;
        flag_z_d    = alu_zero;
        flag_c_d    = alu_carry;
        op_count_d  = op_count_q + 8'd1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      mode_q      <= 4'd0;
      res_data_q  <= 8'd0;
      res_zero_q  <= 1'b0;
      res_carry_q <= 1'b0;
      res_err_q   <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      op_count_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_carry_q <= res_carry_d;
      res_err_q   <= res_err_d;
      flag_z_q    <= flag_z_d;
      flag_c_q    <= flag_c_d;
      op_count_q  <= op_count_d;
    end
  end

  // Handshake and ALU enables decode straight from the state register so
  // that an asynchronous reset drops them without waiting for a clock.
  assign req_ready = (state_q == S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign alu_ee    = (state_q == S_EVAL) || (state_q == S_CAPTURE);
  assign alu_eo    = (state_q == S_CAPTURE);

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_mode  = mode_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign res_carry = res_carry_q;
  assign res_err   = res_err_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign op_count  = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Directed self-checking bench for alu_sequencer. A behavioural
//                ALU answers on the bus only while alu_eo is high. A second
//                instance with SETTLE=4 is used for the mid-operation reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd2, OP_INC = 4'd3,
                         OP_DEC = 4'd4, OP_AND = 4'd5, OP_OR = 4'd6,
                         OP_XOR = 4'd7, OP_SQRT = 4'd8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       req_valid = 1'b0, req_valid4 = 1'b0, res_ready = 1'b0;
  logic [3:0] req_op = 4'd0;
  logic [7:0] req_a = 8'd0, req_b = 8'd0;

  logic       req_ready, alu_ee, alu_eo, alu_zero, alu_carry;
  logic [7:0] alu_a, alu_b, alu_out, res_data, op_count;
  logic [3:0] alu_mode;
  logic       res_valid, res_zero, res_carry, res_err, flag_z, flag_c;

  logic       req_ready4, alu_ee4, alu_eo4, alu_zero4, alu_carry4;
  logic [7:0] alu_a4, alu_b4, alu_out4, res_data4, op_count4;
  logic [3:0] alu_mode4;
  logic       res_valid4, res_zero4, res_carry4, res_err4, flag_z4, flag_c4;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;

  // Returns {zero, carry, result}.
  function automatic logic [9:0] alu_model(input logic [3:0] m,
                                           input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    c = 1'b0;
    r = 8'd0;
    case (m)
      OP_ADD, 4'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
      OP_SUB:  begin r = a - b; c = (a < b); end
      OP_INC:  begin s = {1'b0, a} + 9'd1; r = s[7:0]; c = s[8]; end
      OP_DEC:  begin r = a - 8'd1; c = (a == 8'd0); end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SQRT: for (int i = 0; i < 16; i++) if (i * i <= int'(a)) r = 8'(i);
      default: r = 8'd0;
    endcase
    return {(r == 8'd0), c, r};
  endfunction

  logic [9:0] m1, m4;
  assign m1 = alu_model(alu_mode, alu_a, alu_b);
  assign m4 = alu_model(alu_mode4, alu_a4, alu_b4);
  // Off-bus values are deliberately wrong so a mistimed capture is visible.
  assign alu_out    = alu_eo ? m1[7:0] : 8'hA5;
  assign alu_zero   = alu_eo ? m1[9] : 1'b1;
  assign alu_carry  = alu_eo ? m1[8] : 1'b1;
  assign alu_out4   = alu_eo4 ? m4[7:0] : 8'hA5;
  assign alu_zero4  = alu_eo4 ? m4[9] : 1'b1;
  assign alu_carry4 = alu_eo4 ? m4[8] : 1'b1;

  alu_sequencer #(.SETTLE(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
    .alu_ee(alu_ee), .alu_eo(alu_eo), .alu_out(alu_out),
    .alu_zero(alu_zero), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_carry(res_carry), .res_err(res_err),
    .flag_z(flag_z), .flag_c(flag_c), .op_count(op_count)
  );

  alu_sequencer #(.SETTLE(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_mode(alu_mode4),
    .alu_ee(alu_ee4), .alu_eo(alu_eo4), .alu_out(alu_out4),
    .alu_zero(alu_zero4), .alu_carry(alu_carry4),
    .res_valid(res_valid4), .res_ready(res_ready), .res_data(res_data4),
    .res_zero(res_zero4), .res_carry(res_carry4), .res_err(res_err4),
    .flag_z(flag_z4), .flag_c(flag_c4), .op_count(op_count4)
  );

  // Issues one request on dut from an IDLE point just after a clock edge.
  // lat counts edges from the accepting edge (inclusive) up to the edge on
  // which res_valid rises; ee/eo count the cycles the enables were high.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output int ee_n, output int eo_n);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; ee_n = 0; eo_n = 0;
    while (res_valid !== 1'b1 && lat < 40) begin
      ee_n += int'(alu_ee);
      eo_n += int'(alu_eo);
      @(posedge clk); #1;
      lat++;
    end
    ee_n += int'(alu_ee);
    eo_n += int'(alu_eo);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0 || alu_ee !== 1'b0 || alu_eo !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake: ready=%b valid=%b ee=%b eo=%b, required 1 0 0 0",
               req_ready, res_valid, alu_ee, alu_eo);
    end
    checks++;
    if (flag_z !== 1'b0 || flag_c !== 1'b0 || op_count !== 8'd0 || res_data !== 8'd0 ||
        res_err !== 1'b0 || alu_a !== 8'd0 || alu_mode !== 4'd0) begin
      failures++;
      $display("FAIL reset_regs: fz=%b fc=%b cnt=%0d data=%h err=%b a=%h mode=%h, required all 0",
               flag_z, flag_c, op_count, res_data, res_err, alu_a, alu_mode);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_add();
    int lat, ee_n, eo_n;
    issue(OP_ADD, 8'd200, 8'd100, lat, ee_n, eo_n);
    exp_count++;
    checks++;
    if (lat != 4) begin
      failures++; $display("FAIL add_latency: got %0d edges, required 4", lat);
    end
    checks++;
    if (res_data !== 8'h2C || res_carry !== 1'b1 || res_zero !== 1'b0 || res_err !== 1'b0) begin
      failures++;
      $display("FAIL add_result: data=%h c=%b z=%b err=%b, required 2c 1 0 0",
               res_data, res_carry, res_zero, res_err);
    end
    checks++;
    if (flag_c !== 1'b1 || flag_z !== 1'b0 || op_count !== 8'd1) begin
      failures++;
      $display("FAIL add_flags: fc=%b fz=%b cnt=%0d, required 1 0 1", flag_c, flag_z, op_count);
    end
    checks++;
    if (ee_n != 2 || eo_n != 1) begin
      failures++; $display("FAIL add_enables: ee=%0d eo=%0d cycles, required 2 1", ee_n, eo_n);
    end
    consume();
  endtask

  task automatic test_sub();
    int lat, ee_n, eo_n;
    issue(OP_SUB, 8'd5, 8'd5, lat, ee_n, eo_n);
    exp_count++;
    checks++;
    if (res_data !== 8'd0 || res_zero !== 1'b1 || res_carry !== 1'b0) begin
      failures++;
      $display("FAIL sub_result: data=%h z=%b c=%b, required 00 1 0", res_data, res_zero, res_carry);
    end
    checks++;
    if (flag_z !== 1'b1 || flag_c !== 1'b0 || op_count !== 8'd2) begin
      failures++;
      $display("FAIL sub_flags: fz=%b fc=%b cnt=%0d, required 1 0 2", flag_z, flag_c, op_count);
    end
    checks++;
    if (eo_n != 1) begin
      failures++; $display("FAIL sub_eo_pulse: eo high %0d cycles, required 1", eo_n);
    end
    consume();
  endtask

  task automatic test_illegal();
    int lat, ee_n, eo_n;
    logic [3:0] ops [2];
    ops[0] = 4'hF;
    ops[1] = 4'h9;
    for (int k = 0; k < 2; k++) begin
      issue(ops[k], 8'h12, 8'h34, lat, ee_n, eo_n);
      checks++;
      if (lat != 1 || res_err !== 1'b1 || res_data !== 8'd0) begin
        failures++;
        $display("FAIL illegal_result op=%h: lat=%0d err=%b data=%h, required 1 1 00",
                 ops[k], lat, res_err, res_data);
      end
      checks++;
      if (ee_n != 0 || eo_n != 0) begin
        failures++;
        $display("FAIL illegal_enables op=%h: ee=%0d eo=%0d, required 0 0", ops[k], ee_n, eo_n);
      end
      checks++;
      if (flag_z !== 1'b1 || flag_c !== 1'b0 || op_count !== 8'(exp_count)) begin
        failures++;
        $display("FAIL illegal_state op=%h: fz=%b fc=%b cnt=%0d, required 1 0 %0d",
                 ops[k], flag_z, flag_c, op_count, exp_count);
      end
      consume();
    end
  endtask

  task automatic test_ops();
    int lat, ee_n, eo_n;
    logic [3:0] op [6];
    logic [7:0] a [6], b [6], d [6];
    logic       z [6], c [6];
    op[0] = OP_AND;  a[0] = 8'hF0; b[0] = 8'h3C; d[0] = 8'h30; z[0] = 0; c[0] = 0;
    op[1] = OP_OR;   a[1] = 8'hF0; b[1] = 8'h3C; d[1] = 8'hFC; z[1] = 0; c[1] = 0;
    op[2] = OP_XOR;  a[2] = 8'hF0; b[2] = 8'hF0; d[2] = 8'h00; z[2] = 1; c[2] = 0;
    op[3] = OP_INC;  a[3] = 8'hFF; b[3] = 8'h00; d[3] = 8'h00; z[3] = 1; c[3] = 1;
    op[4] = OP_DEC;  a[4] = 8'h00; b[4] = 8'h00; d[4] = 8'hFF; z[4] = 0; c[4] = 1;
    op[5] = OP_SQRT; a[5] = 8'd81; b[5] = 8'h00; d[5] = 8'h09; z[5] = 0; c[5] = 0;
    for (int k = 0; k < 6; k++) begin
      issue(op[k], a[k], b[k], lat, ee_n, eo_n);
      exp_count++;
      checks++;
      if (lat != 4 || res_data !== d[k] || res_zero !== z[k] || res_carry !== c[k] ||
          flag_z !== z[k] || flag_c !== c[k] || op_count !== 8'(exp_count)) begin
        failures++;
        $display("FAIL op_%0d mode=%h: lat=%0d data=%h z=%b c=%b fz=%b fc=%b cnt=%0d, required 4 %h %b %b %b %b %0d",
                 k, op[k], lat, res_data, res_zero, res_carry, flag_z, flag_c, op_count,
                 d[k], z[k], c[k], z[k], c[k], exp_count);
      end
      consume();
    end
  endtask

  task automatic test_hold();
    int lat, ee_n, eo_n;
    issue(OP_XOR, 8'hF0, 8'h3C, lat, ee_n, eo_n);
    exp_count++;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_a = 8'(i + 1);
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b1 || res_data !== 8'hCC || req_ready !== 1'b0 || alu_a !== 8'hF0) begin
        failures++;
        $display("FAIL hold_%0d: valid=%b data=%h ready=%b alu_a=%h, required 1 cc 0 f0",
                 i, res_valid, res_data, req_ready, alu_a);
      end
    end
    req_valid = 1'b0;
    consume();
    checks++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_release: ready=%b valid=%b, required 1 0", req_ready, res_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lat, ee_n, eo_n;
    int n;
    n = 256 - exp_count;
    for (int i = 0; i < n; i++) begin
      issue(OP_ADD, 8'(i), 8'd1, lat, ee_n, eo_n);
      consume();
    end
    checks++;
    if (op_count !== 8'd0) begin
      failures++; $display("FAIL wrap_256: op_count=%0d, required 0", op_count);
    end
    issue(OP_ADD, 8'd7, 8'd9, lat, ee_n, eo_n);
    consume();
    checks++;
    if (op_count !== 8'd1 || res_data !== 8'd16) begin
      failures++;
      $display("FAIL wrap_257: op_count=%0d data=%0d, required 1 16", op_count, res_data);
    end
  endtask

  task automatic test_reset_mid();
    req_valid4 = 1'b1; req_op = OP_ADD; req_a = 8'd1; req_b = 8'd2;
    @(posedge clk); #1;
    req_valid4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (alu_ee4 !== 1'b1) begin
      failures++; $display("FAIL mid_in_eval: alu_ee=%b, required 1", alu_ee4);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (alu_ee4 !== 1'b0 || req_ready4 !== 1'b1) begin
      failures++;
      $display("FAIL mid_async: alu_ee=%b ready=%b, required 0 1", alu_ee4, req_ready4);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (res_valid4 !== 1'b0 || req_ready4 !== 1'b1 || alu_ee4 !== 1'b0) begin
        failures++;
        $display("FAIL mid_after_%0d: valid=%b ready=%b ee=%b, required 0 1 0",
                 i, res_valid4, req_ready4, alu_ee4);
      end
    end
    checks++;
    if (op_count4 !== 8'd0 || flag_z4 !== 1'b0 || flag_c4 !== 1'b0 ||
        op_count !== 8'd0 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
      failures++;
      $display("FAIL mid_cleared: cnt4=%0d fz4=%b fc4=%b cnt=%0d fz=%b fc=%b, required all 0",
               op_count4, flag_z4, flag_c4, op_count, flag_z, flag_c);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_illegal();
    test_ops();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
